lighthouse_pulse_decoder: RTL and testbench
===========================================

Name: lighthouse_pulse_decoder

Overview:
- Sits directly downstream of the pulse-center capture stage on each photodiode channel.
- Measures the width of every pulse on the same `signal` and takes the pulse center from the capture stage via its ready/clr_ready handshake.
- Classifies each pulse as a sync pulse (decodes skip/data/axis from its width) or a sweep hit.
- Emits one angle sample per valid sweep: sweep center minus the reference sync center, in counter ticks.

Parameters:
- WIDTH, 32, width of free-running counter, center and angle values.
- SYNC_BASE, 3000, nominal width in ticks of a code-0 sync pulse (62.5 us at 48 MHz).
- SYNC_STEP, 500, width increment in ticks per sync code step.
- SWEEP_MAX, 1500, pulses narrower than this are sweep hits.
- SWEEP_TIMEOUT, 400000, maximum ticks from reference sync center to sweep center.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- signal  input  1  synchronized photodiode envelope, same net as the capture stage
- counter  input  WIDTH  free-running tick counter, shared with the capture stage
- center_in  input  WIDTH  pulse center from the capture stage
- center_ready  input  1  capture stage has a center; sticky until cleared
- clr_ready  output  1  one-cycle pulse that acknowledges center_in
- angle  output  WIDTH  sweep center minus reference sync center, modulo 2^WIDTH
- angle_axis  output  1  axis bit of the reference sync
- angle_valid  output  1  one-cycle strobe when angle and angle_axis update
- ootx_bit  output  1  data bit of the most recent sync pulse
- ootx_skip  output  1  skip bit of the most recent sync pulse
- ootx_valid  output  1  one-cycle strobe per decoded sync pulse
- err  output  1  one-cycle strobe on a malformed pulse, handshake miss, or timeout

Behaviour:
- Reset: all outputs 0; state IDLE; internal signal_d 0; pending flag 0. Reset mid-pulse discards the pulse; the next rising edge starts fresh.
- Edge detection uses a registered `signal_d` and the same edge definitions as the capture stage, so both stages see the same edge on the same clock.
  - Rising edge: latch `counter` into rise_ts.
  - Falling edge: width = counter − rise_ts, modulo 2^WIDTH; set pending; start a 4-cycle handshake window.
- Handshake:
  - In a cycle with pending=1 and center_ready=1: latch center_in, drive clr_ready=1 in the next cycle, clear pending, then classify.
  - Window expires with center_ready still 0: clear pending, err=1 for one cycle, no classification.
  - A new falling edge while pending=1 replaces the pending width and raises err.
- Classification, done by a comparator ladder (no divider):
  - width < SWEEP_MAX → SWEEP.
  - code n in 0..7 when SYNC_BASE + n·SYNC_STEP − SYNC_STEP/2 ≤ width < SYNC_BASE + n·SYNC_STEP + SYNC_STEP/2 → SYNC. Decode skip=n[2], data=n[1], axis=n[0].
  - Anything else → err=1; state unchanged.
- Every SYNC updates ootx_bit and ootx_skip and pulses ootx_valid, one cycle after clr_ready.
- State machine, states IDLE and ARMED:
  - IDLE, SYNC with skip=0 → latch ref_center and ref_axis, go to ARMED.
  - IDLE, SYNC with skip=1 or SWEEP → stay IDLE; a SWEEP is dropped silently.
  - ARMED, SYNC with skip=0 → re-arm with the new reference.
  - ARMED, SYNC with skip=1 → stay ARMED; the reference is kept.
  - ARMED, SWEEP → check the distance before reporting:
    - If sweep_center − ref_center ≤ SWEEP_TIMEOUT: angle = that difference, angle_axis = ref_axis, angle_valid=1 for one cycle, go to IDLE.
    - Otherwise: err=1, go to IDLE.
  - ARMED with counter − ref_center > SWEEP_TIMEOUT while no pulse is pending → err=1, go to IDLE.
- Latency: angle_valid and ootx_valid assert exactly 2 cycles after center_ready is first seen high with pending=1.
- All subtractions are modulo 2^WIDTH; counter wrap between sync and sweep gives a correct angle.
- Simultaneous timeout and consumption in the same cycle: consumption wins; the timeout is evaluated against the consumed center.

Test Plan:
- Sync width 3500 (n=1), center 10000, then sweep width 200, center 250000 → ootx_valid with bit=0, skip=0; then angle=240000, angle_axis=1, angle_valid for exactly one cycle; clr_ready once per pulse.
- Skip-sync width 5000 (n=4) after an arming sync width 3000, center 10000, then sweep center 90000 → ootx_skip=1 then angle=80000, angle_axis=0; reference not overwritten.
- Counter near wrap: sync center 0xFFFF_FF00, sweep center 0x0000_0100 → angle=0x200.
- Arm, then no pulse for 400001 ticks → err one cycle, state IDLE; a following sweep produces no angle_valid.
- Pulse width 2000 → err one cycle, no ootx_valid; pulse width 8000 → err.
- center_ready held low for 5 cycles after a falling edge → err, no clr_ready; assert rst mid-pulse → all outputs 0, the next complete sync decodes correctly.

Source files
------------

// File: rtl/lighthouse_pulse_decoder.sv
// lighthouse_pulse_decoder
//   Classifies each pulse on a photodiode channel as a sync pulse or a sweep
//   hit, decodes sync codes (skip/data/axis), and reports sweep angles as the
//   sweep center minus the reference sync center, in counter ticks.
//
//   Pipeline:
//     stage 0  edge detect, width measurement, center handshake window
//     stage 1  consumed width/center registered, clr_ready driven
//     stage 2  comparator-ladder classification, IDLE/ARMED FSM, outputs
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   signal          synchronized photodiode envelope (same net as capture)
//   counter         free-running tick counter shared with the capture stage
//   center_in       pulse center from the capture stage
//   center_ready    capture stage has a center (sticky until clr_ready)
//   clr_ready       one-cycle acknowledge of center_in
//   angle           sweep center - reference sync center (mod 2^WIDTH)
//   angle_axis      axis bit of the reference sync
//   angle_valid     one-cycle strobe when angle/angle_axis update
//   ootx_bit        data bit of the most recent sync
//   ootx_skip       skip bit of the most recent sync
//   ootx_valid      one-cycle strobe per decoded sync
//   err             one-cycle strobe: malformed pulse, handshake miss/overrun,
//                   sweep too late, or reference timeout
module lighthouse_pulse_decoder #(
  parameter int WIDTH         = 32,
  parameter int SYNC_BASE     = 3000,
  parameter int SYNC_STEP     = 500,
  parameter int SWEEP_MAX     = 1500,
  parameter int SWEEP_TIMEOUT = 400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] center_in,
  input  logic             center_ready,
  output logic             clr_ready,
  output logic [WIDTH-1:0] angle,
  output logic             angle_axis,
  output logic             angle_valid,
  output logic             ootx_bit,
  output logic             ootx_skip,
  output logic             ootx_valid,
  output logic             err
);

  typedef enum logic {IDLE, ARMED} state_t;

  // Loaded on the falling edge; the window covers 4 cycles with pending set.
  localparam logic [1:0] WIN_LAST = 2'd3;

  state_t           state;
  logic             signal_d;
  logic             rise, fall;
  logic [WIDTH-1:0] rise_ts;
  logic [WIDTH-1:0] pend_width;
  logic             pending;
  logic [1:0]       win_cnt;
  logic             consume, expire, overrun;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_width;
  logic [WIDTH-1:0] s1_center;

  logic [WIDTH-1:0] ref_center;
  logic             ref_axis;

  logic             is_sweep, is_sync;
  logic [2:0]       code;
  logic [WIDTH-1:0] sweep_dist, idle_dist;
  logic             sweep_late, idle_late;
  logic             timeout, bad_pulse;

  // Same edge definitions as the capture stage so both see one edge per clock.
  assign rise = signal & ~signal_d;
  assign fall = ~signal & signal_d;

  assign consume = pending & center_ready;
  assign expire  = pending & ~center_ready & (win_cnt == '0);
  // A consumed pulse is not lost, so a fall in the consume cycle is no overrun.
  assign overrun = fall & pending & ~center_ready;

  // Comparator ladder over the 8 sync code bins; sweep takes priority.
  always_comb begin
    is_sweep = s1_width < WIDTH'(SWEEP_MAX);
    is_sync  = 1'b0;
    code     = '0;
    for (int n = 0; n < 8; n++) begin
      if (!is_sweep &&
          s1_width >= WIDTH'(SYNC_BASE + n * SYNC_STEP - SYNC_STEP / 2) &&
          s1_width <  WIDTH'(SYNC_BASE + n * SYNC_STEP + SYNC_STEP / 2)) begin
        is_sync = 1'b1;
        code    = 3'(n);
      end
    end
  end

  assign sweep_dist = s1_center - ref_center;
  assign idle_dist  = counter - ref_center;
  assign sweep_late = sweep_dist > WIDTH'(SWEEP_TIMEOUT);
  assign idle_late  = idle_dist > WIDTH'(SWEEP_TIMEOUT);

  // Any pulse in flight (falling now, pending, or being classified) holds off
  // the free-running timeout; the consumed center decides instead.
  assign timeout   = (state == ARMED) & ~fall & ~pending & ~s1_vld & idle_late;
  assign bad_pulse = s1_vld & ((~is_sync & ~is_sweep) |
                               (is_sweep & (state == ARMED) & sweep_late));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      signal_d    <= 1'b0;
      rise_ts     <= '0;
      pend_width  <= '0;
      pending     <= 1'b0;
      win_cnt     <= '0;
      s1_vld      <= 1'b0;
      s1_width    <= '0;
      s1_center   <= '0;
      ref_center  <= '0;
      ref_axis    <= 1'b0;
      clr_ready   <= 1'b0;
      angle       <= '0;
      angle_axis  <= 1'b0;
      angle_valid <= 1'b0;
      ootx_bit    <= 1'b0;
      ootx_skip   <= 1'b0;
      ootx_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      signal_d    <= signal;
      clr_ready   <= 1'b0;
      angle_valid <= 1'b0;
      ootx_valid  <= 1'b0;
      s1_vld      <= 1'b0;
      err         <= overrun | expire | bad_pulse | timeout;

      // stage 0: width and handshake window
      if (rise) rise_ts <= counter;
      if (fall) begin
        pend_width <= counter - rise_ts;
        pending    <= 1'b1;
        win_cnt    <= WIN_LAST;
      end else if (consume || expire) begin
        pending <= 1'b0;
      end else if (pending) begin
        win_cnt <= win_cnt - 2'd1;
      end

      // stage 1: take the center, acknowledge the capture stage
      if (consume) begin
        s1_vld    <= 1'b1;
        s1_width  <= pend_width;
        s1_center <= center_in;
        clr_ready <= 1'b1;
      end

      // stage 2: classify and run the FSM
      if (s1_vld) begin
        if (is_sync) begin
          ootx_valid <= 1'b1;
          ootx_bit   <= code[1];
          ootx_skip  <= code[2];
          if (!code[2]) begin
            state      <= ARMED;
            ref_center <= s1_center;
            ref_axis   <= code[0];
          end
        end else if (is_sweep && state == ARMED) begin
          state <= IDLE;
          if (!sweep_late) begin
            angle       <= sweep_dist;
            angle_axis  <= ref_axis;
            angle_valid <= 1'b1;
          end
        end
      end else if (timeout) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Bench for lighthouse_pulse_decoder: directed scenarios plus random pulses.
// A transaction-level model predicts, per pulse, which outputs fire on which
// cycle; one compare process checks every output on every cycle.
module tb_lighthouse_pulse_decoder;
  localparam int W    = 32;
  localparam int BASE = 3000;
  localparam int STEP = 500;
  localparam int SMAX = 1500;
  localparam int TO   = 400000;

  logic         clk = 1'b0;
  logic         rst;
  logic         signal;
  logic [W-1:0] counter;
  logic [W-1:0] center_in;
  logic         center_ready;
  logic         clr_ready;
  logic [W-1:0] angle;
  logic         angle_axis, angle_valid;
  logic         ootx_bit, ootx_skip, ootx_valid;
  logic         err;

  lighthouse_pulse_decoder #(
    .WIDTH(W), .SYNC_BASE(BASE), .SYNC_STEP(STEP),
    .SWEEP_MAX(SMAX), .SWEEP_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .signal(signal), .counter(counter),
    .center_in(center_in), .center_ready(center_ready), .clr_ready(clr_ready),
    .angle(angle), .angle_axis(angle_axis), .angle_valid(angle_valid),
    .ootx_bit(ootx_bit), .ootx_skip(ootx_skip), .ootx_valid(ootx_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  // Expected events on a given cycle.
  typedef struct packed {
    logic         clr, ov, av, er, ob, os, ax;
    logic [W-1:0] ang;
  } ev_t;

  ev_t sched [int];
  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  // model state
  logic         m_armed;
  logic [W-1:0] m_ref;
  logic         m_refax;
  logic [W-1:0] cur_cnt;
  logic         h_ob, h_os, h_ax;
  logic [W-1:0] h_ang;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t get_ev(input int c);
    if (sched.exists(c)) return sched[c];
    return '0;
  endfunction

  task automatic sch_err(input int c);
    ev_t e = get_ev(c);
    e.er = 1'b1; sched[c] = e;
  endtask

  task automatic sch_clr(input int c);
    ev_t e = get_ev(c);
    e.clr = 1'b1; sched[c] = e;
  endtask

  task automatic sch_ootx(input int c, input logic b, input logic s);
    ev_t e = get_ev(c);
    e.ov = 1'b1; e.ob = b; e.os = s; sched[c] = e;
  endtask

  task automatic sch_ang(input int c, input logic [W-1:0] a, input logic x);
    ev_t e = get_ev(c);
    e.av = 1'b1; e.ang = a; e.ax = x; sched[c] = e;
  endtask

  task automatic model_reset();
    sched.delete();
    m_armed = 1'b0; m_ref = '0; m_refax = 1'b0;
    h_ob = 1'b0; h_os = 1'b0; h_ax = 1'b0; h_ang = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ev_t e;
      e = get_ev(cyc);
      if (e.ov) begin h_ob = e.ob; h_os = e.os; end
      if (e.av) begin h_ang = e.ang; h_ax = e.ax; end
      n_chk++;
      if ({clr_ready, ootx_valid, angle_valid, err, ootx_bit, ootx_skip, angle_axis, angle} !==
          {e.clr, e.ov, e.av, e.er, h_ob, h_os, h_ax, h_ang}) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got clr=%b ov=%b av=%b err=%b bit=%b skip=%b ax=%b angle=%0h, expected clr=%b ov=%b av=%b err=%b bit=%b skip=%b ax=%b angle=%0h",
                 cyc, clr_ready, ootx_valid, angle_valid, err, ootx_bit, ootx_skip, angle_axis, angle,
                 e.clr, e.ov, e.av, e.er, h_ob, h_os, h_ax, h_ang);
      end
    end
  end

  task automatic lit(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Free-running timeout, evaluated at the next edge with no pulse in flight.
  task automatic check_timeout(input int c);
    if (m_armed && (cur_cnt - m_ref) > W'(TO)) begin
      sch_err(c);
      m_armed = 1'b0;
    end
  endtask

  task automatic set_cnt(input logic [W-1:0] v);
    counter = v; cur_cnt = v;
    check_timeout(cyc + 1);
  endtask

  // Decide a consumed pulse from its width and center alone.
  task automatic classify(input logic [W-1:0] w, input logic [W-1:0] ctr, input int c);
    logic [W-1:0] lo0 = W'(BASE - STEP / 2);
    int n;
    if (w < W'(SMAX)) begin
      if (m_armed) begin
        if ((ctr - m_ref) <= W'(TO)) sch_ang(c, ctr - m_ref, m_refax);
        else sch_err(c);
        m_armed = 1'b0;
      end
    end else if (w >= lo0 && (w - lo0) / W'(STEP) <= 7) begin
      n = int'((w - lo0) / W'(STEP));
      sch_ootx(c, n[1], n[2]);
      if (!n[2]) begin m_armed = 1'b1; m_ref = ctr; m_refax = n[0]; end
    end else begin
      sch_err(c);
    end
  endtask

  // One pulse centred on ctr, width w; center_ready raised d cycles after the
  // falling edge is registered (d=0: never, the window expires).
  task automatic pulse(input logic [W-1:0] w, input logic [W-1:0] ctr, input int d, input int hold);
    logic [W-1:0] r;
    int j, e;
    r = ctr - (w >> 1);
    signal = 1'b1;
    set_cnt(r);
    step();
    repeat (hold) step();
    signal = 1'b0;
    counter = r + w; cur_cnt = r + w;
    j = cyc;
    step();
    if (d >= 1 && d <= 4) begin
      repeat (d - 1) step();
      center_ready = 1'b1; center_in = ctr;
      e = j + d + 1;
      sch_clr(e);
      classify(w, ctr, e + 1);
      check_timeout(e + 2);
      step();
      center_ready = 1'b0;
      repeat (3) step();
    end else begin
      sch_err(j + 5);
      check_timeout(j + 6);
      repeat (6) step();
    end
  endtask

  task automatic check_zero(input string tag);
    lit({tag, " clr_ready"},   W'(clr_ready),   '0);
    lit({tag, " angle"},       angle,           '0);
    lit({tag, " angle_axis"},  W'(angle_axis),  '0);
    lit({tag, " angle_valid"}, W'(angle_valid), '0);
    lit({tag, " ootx_bit"},    W'(ootx_bit),    '0);
    lit({tag, " ootx_skip"},   W'(ootx_skip),   '0);
    lit({tag, " ootx_valid"},  W'(ootx_valid),  '0);
    lit({tag, " err"},         W'(err),         '0);
  endtask

  initial begin
    logic [W-1:0] t, w;
    int bw [4];
    rst = 1'b1; signal = 1'b0; counter = '0; center_in = '0; center_ready = 1'b0;
    cur_cnt = '0;
    model_reset();
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();
    chk_en = 1'b1;

    // sync n=1 then sweep: angle 240000, axis 1
    pulse(3500, 10000, 2, 1);
    lit("sync1 ootx_bit", W'(ootx_bit), 0);
    lit("sync1 ootx_skip", W'(ootx_skip), 0);
    pulse(200, 250000, 1, 2);
    lit("sweep1 angle", angle, 240000);
    lit("sweep1 axis", W'(angle_axis), 1);

    // arm n=0, skip sync n=4, sweep: reference kept
    pulse(3000, 10000, 3, 0);
    pulse(5000, 30000, 1, 1);
    lit("skip ootx_skip", W'(ootx_skip), 1);
    pulse(200, 90000, 4, 0);
    lit("skip angle", angle, 80000);
    lit("skip axis", W'(angle_axis), 0);

    // counter wrap
    pulse(3000, 32'hFFFF_FF00, 1, 0);
    pulse(200, 32'h0000_0100, 2, 0);
    lit("wrap angle", angle, 32'h200);

    // reference timeout boundary: exactly TO is fine, TO+1 times out
    pulse(3000, 20000, 1, 0);
    set_cnt(20000 + TO); step(); step();
    set_cnt(20000 + TO + 1); step(); step();
    pulse(200, 20000 + TO + 100, 1, 0);

    // sweep distance boundary
    pulse(3500, 1000000, 1, 0);
    pulse(200, 1000000 + TO, 1, 0);
    lit("edge angle", angle, TO);
    pulse(3500, 2000000, 1, 0);
    pulse(200, 2000000 + TO + 1, 1, 0);

    // malformed widths and bin edges
    pulse(2000, 3000000, 1, 0);
    pulse(8000, 3100000, 2, 0);
    bw = '{1499, 1500, 2749, 2750};
    foreach (bw[i]) pulse(bw[i], 3200000 + 100000 * i, 1, 0);

    // handshake window expires
    pulse(3000, 4000000, 0, 1);

    // reset mid-pulse, then a clean sync n=3
    signal = 1'b1; set_cnt(4100000); step(); step();
    chk_en = 1'b0;
    rst = 1'b1; signal = 1'b0;
    step(); step();
    check_zero("midreset");
    model_reset();
    rst = 1'b0;
    step();
    chk_en = 1'b1;
    pulse(4500, 4200000, 3, 0);
    lit("postreset ootx_bit", W'(ootx_bit), 1);
    lit("postreset ootx_skip", W'(ootx_skip), 0);

    // random traffic
    t = $urandom;
    for (int i = 0; i < 160; i++) begin
      int kind, d;
      kind = $urandom_range(0, 9);
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      if (kind <= 3)      w = W'(BASE - STEP / 2 + $urandom_range(0, 7) * STEP + $urandom_range(0, STEP - 1));
      else if (kind <= 7) w = W'($urandom_range(1, SMAX - 1));
      else if (kind == 8) w = ($urandom_range(0, 1) == 1) ? W'($urandom_range(SMAX, 2749)) : W'($urandom_range(6750, 9000));
      else w = '0;
      if (kind == 9) begin
        set_cnt(cur_cnt + W'($urandom_range(300000, 500000)));
        step(); step();
        t = cur_cnt;
      end else begin
        t = t + (($urandom_range(0, 5) == 0) ? W'($urandom_range(380000, 420000))
                                               : W'($urandom_range(5000, 120000)));
        pulse(w, t, d, $urandom_range(0, 3));
      end
    end

    repeat (4) step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
